tmr_word_voter_tracked: RTL

Registered TMR word voter with a valid/ready handshake and per-lane fault tracking. A lane that loses the vote FaultThreshold times in a row is marked faulty. The voter then degrades to a DMR compare of the two remaining lanes. It sits at the output of triplicated datapaths and reports lane health to the recovery controller.

---
 rtl/tmr_word_voter_tracked.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tmr_word_voter_tracked.sv
// Registered TMR word voter with valid/ready handshake, per-lane fault tracking
// and TRIPLE -> DEGRADED -> FAILED degradation. Optional macro: TMR_VOTER_STATS_EN.
module tmr_word_voter_tracked #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned FaultThreshold = 4,
    parameter int unsigned CntWidth       = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DataWidth-1:0]    data_a_i,
    input  logic [DataWidth-1:0]    data_b_i,
    input  logic [DataWidth-1:0]    data_c_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DataWidth-1:0]    data_o,
    output logic                    error_o,
    output logic [2:0]              error_cba_o,
    output logic [2:0]              faulty_o,
    output logic                    failed_o,
    input  logic                    clear_i,
    output logic [3*CntWidth-1:0]   mismatch_cnt_o
);

    typedef enum logic [1:0] {TRIPLE, DEGRADED, FAILED} state_e;

    localparam int unsigned ConsW = $clog2(FaultThreshold + 1);
    localparam logic [ConsW-1:0] ConsMax = ConsW'(FaultThreshold);

    state_e                    state_q, state_d;
    logic [2:0]                faulty_q, faulty_d;
    logic [2:0][ConsW-1:0]     cons_q, cons_d;

    logic                      valid_q;
    logic [DataWidth-1:0]      data_q;
    logic                      err_q;
    logic [2:0]                cba_q;

    logic                      accept;
    logic [DataWidth-1:0]      vote_data, rem_lo, rem_hi;
    logic                      vote_err;
    logic [2:0]                vote_cba;

    assign ready_o     = !valid_q || ready_i;
    assign accept      = valid_i && ready_o;
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign error_o     = err_q;
    assign error_cba_o = cba_q;
    assign faulty_o    = faulty_q;
    assign failed_o    = (state_q == FAILED);

    // The two lanes still trusted once one lane is marked faulty.
    always_comb begin
        rem_lo = data_a_i;
        rem_hi = data_b_i;
        if (faulty_q[0]) begin
            rem_lo = data_b_i;
            rem_hi = data_c_i;
        end else if (faulty_q[1]) begin
            rem_hi = data_c_i;
        end
    end

    always_comb begin
        vote_data = data_a_i;
        vote_err  = 1'b0;
        vote_cba  = 3'b000;
        unique case (state_q)
            TRIPLE: begin
                if (data_a_i == data_b_i) begin
                    vote_cba = {data_c_i != data_a_i, 2'b00};
                end else if (data_a_i == data_c_i) begin
                    vote_cba = 3'b010;
                end else if (data_b_i == data_c_i) begin
                    vote_data = data_b_i;
                    vote_cba  = 3'b001;
                end else begin
                    vote_data = (data_a_i & data_b_i) | (data_a_i & data_c_i) |
                                (data_b_i & data_c_i);
                    vote_err  = 1'b1;
                    vote_cba  = 3'b111;
                end
            end
            DEGRADED: begin
                vote_data = rem_lo;
                if (rem_lo == rem_hi) begin
                    vote_cba = faulty_q;
                end else begin
                    vote_err = 1'b1;
                    vote_cba = 3'b111;
                end
            end
            default: begin
                vote_err = 1'b1;
                vote_cba = 3'b111;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        faulty_d = faulty_q;
        cons_d   = cons_q;
        if (accept) begin
            // Uncorrectable votes say nothing about which lane is bad.
            if (!vote_err) begin
                for (int i = 0; i < 3; i++) begin
                    if (vote_cba[i])
                        cons_d[i] = (cons_q[i] == ConsMax) ? ConsMax : cons_q[i] + 1'b1;
                    else
                        cons_d[i] = '0;
                end
            end
            if (state_q == TRIPLE) begin
                for (int i = 0; i < 3; i++) begin
                    if (cons_d[i] == ConsMax) begin
                        faulty_d[i] = 1'b1;
                        state_d     = DEGRADED;
                    end
                end
            end else if (state_q == DEGRADED && vote_err) begin
                state_d = FAILED;
            end
        end
        if (clear_i) begin
            state_d  = TRIPLE;
            faulty_d = '0;
            cons_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TRIPLE;
            faulty_q <= '0;
            cons_q   <= '0;
        end else begin
            state_q  <= state_d;
            faulty_q <= faulty_d;
            cons_q   <= cons_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cba_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= vote_data;
            err_q   <= vote_err;
            cba_q   <= vote_cba;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

`ifdef TMR_VOTER_STATS_EN
    logic [2:0][CntWidth-1:0] cnt_q;

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                cnt_q[g] <= '0;
            else if (clear_i)
                cnt_q[g] <= '0;
            else if (accept && vote_cba[g] && (cnt_q[g] != {CntWidth{1'b1}}))
                cnt_q[g] <= cnt_q[g] + 1'b1;
        end
    end

    assign mismatch_cnt_o = cnt_q;
`else
    assign mismatch_cnt_o = '0;
`endif

endmodule
